sdram_arbiter: RTL

Central command-bus arbiter and sequencer for the SDRAM controller. It owns the single SDRAM command, address, bank and DQ-drive path and grants it to four requesters: init, auto-refresh, write and read. Refresh has strict priority. Write and read alternate round-robin. A grant watchdog recovers from a requester that never signals end.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_grant_wdog.sv | 24 ++
 rtl/sdram_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared state encodings, SDRAM command constants and requester ids
package sdram_pkg;
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;
  typedef enum logic [1:0] {REQ_INIT, REQ_AREF, REQ_WRITE, REQ_READ} req_t;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
endpackage

// File: rtl/sdram_grant_wdog.sv
// sdram_grant_wdog: saturating grant-hold counter with expiry flag and error pulse
module sdram_grant_wdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic sclk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  input  logic done,
  output logic expire,
  output logic err_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] MAX = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt;
  assign expire = en & (cnt == MAX);
  // count grant cycles, clear on state change, hold at the limit
  always_ff @(posedge sclk)
    if (srst || clr) cnt <= '0;
    else if (en && cnt != MAX) cnt <= cnt + 1'b1;
  // a real end pulse on the expiry cycle suppresses the error
  always_ff @(posedge sclk)
    err_timeout <= ~srst & expire & ~done;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: command-bus arbiter for init, refresh, write and read requesters
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int BANK_W      = 2,
  parameter int DQ_W        = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              sclk,
  input  logic              srst,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              flag_aref_ask,
  input  logic              flag_aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              flag_wr_ask,
  input  logic              flag_wr_end,
  input  logic [3:0]        write_cmd,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [BANK_W-1:0] write_bank,
  input  logic [DQ_W-1:0]   write_data,
  input  logic              flag_rd_ask,
  input  logic              flag_rd_end,
  input  logic [3:0]        read_cmd,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [BANK_W-1:0] read_bank,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic              err_timeout,
  output logic [2:0]        grant_state
);
  state_t state, state_nxt;
  req_t   last_grant;
  logic   busy, done, expire;
  assign busy = state == S_AREF || state == S_WRITE || state == S_READ;
  assign done = state == S_AREF  ? flag_aref_end :
                state == S_WRITE ? flag_wr_end   :
                state == S_READ  ? flag_rd_end   : 1'b0;
  sdram_grant_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .sclk        (sclk),
    .srst        (srst),
    .clr         (state_nxt != state),
    .en          (busy),
    .done        (done),
    .expire      (expire),
    .err_timeout (err_timeout)
  );
  // next state: refresh first, then write/read round-robin on ties
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  state_nxt = flag_init_end ? S_ARBIT : S_INIT;
      S_ARBIT: state_nxt = flag_aref_ask ? S_AREF :
                           (flag_wr_ask && flag_rd_ask) ? (last_grant == REQ_READ ? S_WRITE : S_READ) :
                           flag_wr_ask ? S_WRITE :
                           flag_rd_ask ? S_READ : S_ARBIT;
      S_AREF, S_WRITE, S_READ: state_nxt = (done || expire) ? S_ARBIT : state;
      default: state_nxt = S_INIT;
    endcase
  end
  // state register
  always_ff @(posedge sclk)
    state <= srst ? S_INIT : state_nxt;
  // remember the last data grant so the next tie goes the other way
  always_ff @(posedge sclk)
    if (srst) last_grant <= REQ_READ;
    else if (state == S_ARBIT && state_nxt == S_WRITE) last_grant <= REQ_WRITE;
    else if (state == S_ARBIT && state_nxt == S_READ) last_grant <= REQ_READ;
  // command-bus mux driven from the registered state
  always_comb begin
    sdram_cmd  = state == S_INIT  ? init_cmd  :
                 state == S_AREF  ? aref_cmd  :
                 state == S_WRITE ? write_cmd :
                 state == S_READ  ? read_cmd  : CMD_NOP;
    sdram_addr = state == S_INIT  ? init_addr  :
                 state == S_AREF  ? aref_addr  :
                 state == S_WRITE ? write_addr :
                 state == S_READ  ? read_addr  : '0;
    sdram_bank = state == S_WRITE ? write_bank :
                 state == S_READ  ? read_bank  : '0;
  end
  assign aref_en      = state == S_AREF;
  assign wr_en        = state == S_WRITE && !flag_aref_ask;
  assign rd_en        = state == S_READ && !flag_aref_ask;
  assign sdram_dq_oe  = state == S_WRITE;
  assign sdram_dq_out = write_data;
  assign grant_state  = state;
endmodule
